edge_word_packer: RTL and testbench

Downstream consumer of the Sobel stage: takes the 8-bit gradient stream (one beat per valid cycle, `WIDTH-2` beats per output row, `HEIGHT-2` rows per frame) and suppresses weak gradients below a runtime threshold. It packs four pixels per 32-bit word, marks end-of-line and end-of-frame, and buffers words in a small FIFO behind a ready/valid interface toward the memory writer. The FIFO absorbs short stalls; sustained backpressure drops words and raises a sticky overflow flag.

---
 rtl/sobel_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/edge_word_packer.sv | 119 +++++++++++
 tb/tb_edge_word_packer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared widths, FIFO entry layout and the threshold helper for the edge word packer.
package sobel_pkg;

    localparam int PIX_W   = 8;
    localparam int LANES   = 4;
    localparam int WORD_W  = PIX_W * LANES;
    localparam int ENTRY_W = WORD_W + 2;

    typedef logic [$clog2(LANES)-1:0] lane_t;

    typedef struct packed {
        logic              eof;
        logic              eol;
        logic [WORD_W-1:0] data;
    } entry_t;

    function automatic logic [PIX_W-1:0] suppress(input logic [PIX_W-1:0] pix,
                                                  input logic [PIX_W-1:0] th);
        return (pix >= th) ? pix : {PIX_W{1'b0}};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head that reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == {CW{1'b0}});
    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign pop_ok_s  = pop_i && !empty_o;
    assign push_ok_s = push_i && (!full_o || pop_ok_s);
    assign rdata_o   = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are masked by empty_o, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/edge_word_packer.sv
// Thresholds Sobel gradient beats, packs four per word with row/frame tags,
// and queues the words toward the memory writer; drops are recorded in a sticky flag.
module edge_word_packer
    import sobel_pkg::*;
#(
    parameter int WIDTH      = 128,
    parameter int HEIGHT     = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [PIX_W-1:0]  pixel_in,
    input  logic [PIX_W-1:0]  thresh,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_eol,
    output logic              out_eof,
    output logic              overflow
);

    localparam int COLS = WIDTH - 2;
    localparam int ROWS = HEIGHT - 2;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    lane_t             lane_q, lane_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic              overflow_q, overflow_d;

    logic [PIX_W-1:0]  pix_s;
    logic [WORD_W-1:0] word_s;
    logic              row_end_s;
    logic              frame_end_s;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;
    entry_t            wr_entry_s;
    entry_t            rd_entry_s;

    // Assembly, framing counters and drop detection.
    always_comb begin
        lane_d      = lane_q;
        col_d       = col_q;
        row_d       = row_q;
        asm_d       = asm_q;
        pix_s       = suppress(pixel_in, thresh);
        word_s      = asm_q | ({{(WORD_W-PIX_W){1'b0}}, pix_s} << {lane_q, 3'b000});
        row_end_s   = (col_q == CW'(COLS - 1));
        frame_end_s = row_end_s && (row_q == RW'(ROWS - 1));
        push_s      = valid_in && ((lane_q == lane_t'(LANES - 1)) || row_end_s);
        if (valid_in) begin
            if (row_end_s) begin
                col_d  = {CW{1'b0}};
                lane_d = {$bits(lane_t){1'b0}};
                row_d  = frame_end_s ? {RW{1'b0}} : row_q + RW'(1);
            end else begin
                col_d  = col_q + CW'(1);
                lane_d = lane_q + lane_t'(1);
                row_d  = row_q;
            end
            // Clearing after each push leaves unfilled tail lanes at zero.
            asm_d = push_s ? {WORD_W{1'b0}} : word_s;
        end else begin
            lane_d = lane_q;
            col_d  = col_q;
            row_d  = row_q;
            asm_d  = asm_q;
        end
        overflow_d = overflow_q | (push_s && full_s && !pop_s);
    end

    // Packer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q     <= {$bits(lane_t){1'b0}};
            col_q      <= {CW{1'b0}};
            row_q      <= {RW{1'b0}};
            asm_q      <= {WORD_W{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            lane_q     <= lane_d;
            col_q      <= col_d;
            row_q      <= row_d;
            asm_q      <= asm_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_entry_s.eof  = frame_end_s;
    assign wr_entry_s.eol  = row_end_s;
    assign wr_entry_s.data = word_s;
    assign pop_s           = out_valid && out_ready;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (wr_entry_s),
        .rdata_o (rd_entry_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign out_valid = !empty_s;
    assign out_data  = rd_entry_s.data;
    assign out_eol   = rd_entry_s.eol;
    assign out_eof   = rd_entry_s.eof;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_edge_word_packer.sv
// Directed bench for edge_word_packer at default geometry (126x126 output, depth-4 FIFO).
module tb_edge_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [7:0]  pixel_in;
    logic [7:0]  thresh;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_eol;
    logic        out_eof;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    logic [33:0] q[$];

    typedef struct packed {
        logic [31:0] px;
        logic [7:0]  th;
        logic [31:0] exp;
    } vec_t;

    edge_word_packer dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .pixel_in  (pixel_in),
        .thresh    (thresh),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Scoreboard capture of every accepted word as {eof, eol, data}.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) q.push_back({out_eof, out_eol, out_data});
    end

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_in = 1'b0;
        @(posedge clk); #1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic beat(input logic [7:0] p, input logic [7:0] th);
        valid_in = 1'b1;
        pixel_in = p;
        thresh   = th;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (q.size() < n && k < budget) begin @(posedge clk); #1; k++; end
        checks++;
        if (q.size() < n) begin
            errors++;
            $display("FAIL wait_words: got %0d words expected %0d", q.size(), n);
        end
    endtask

    // Ramp stream: pixel value = column, thresh 0.
    task automatic ramp_cols(input int c0, input int c1);
        for (int c = c0; c <= c1; c++) beat(8'(c), 8'd0);
    endtask

    function automatic logic [31:0] ramp_word(input int k);
        logic [31:0] w = 32'h0;
        for (int l = 0; l < 4; l++) begin
            int c = 4 * k + l;
            if (c < 126) w[8*l +: 8] = 8'(c);
        end
        return w;
    endfunction

    initial begin
        vec_t vecs[6];
        int   bad;
        vecs[0] = '{px: 32'h03020100, th: 8'd0,   exp: 32'h03020100};
        vecs[1] = '{px: 32'h63966432, th: 8'd100, exp: 32'h00966400};
        vecs[2] = '{px: 32'hFF00FEFF, th: 8'd255, exp: 32'hFF0000FF};
        vecs[3] = '{px: 32'h281E140A, th: 8'd30,  exp: 32'h281E0000};
        vecs[4] = '{px: 32'h01817F80, th: 8'h80,  exp: 32'h00810080};
        vecs[5] = '{px: 32'hDDCCBBAA, th: 8'hBB,  exp: 32'hDDCCBB00};

        valid_in = 1'b0; pixel_in = 8'd0; thresh = 8'd0; out_ready = 1'b0;
        do_reset();
        chk("reset_valid", 34'(out_valid), 34'd0);
        chk("reset_data",  34'(out_data),  34'd0);
        chk("reset_eol",   34'(out_eol),   34'd0);
        chk("reset_eof",   34'(out_eof),   34'd0);
        chk("reset_ovf",   34'(overflow),  34'd0);

        // Table of threshold/packing vectors, one word each.
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            for (int l = 0; l < 4; l++) beat(vecs[v].px[8*l +: 8], vecs[v].th);
            chk("latency_valid", 34'(out_valid), 34'd1);
            chk("latency_data",  34'(out_data),  34'(vecs[v].exp));
        end
        wait_words(6, 20);
        idle(3);
        chk("table_count", 34'(q.size()), 34'd6);
        for (int v = 0; v < 6; v++) chk("table_word", q[v], {2'b00, vecs[v].exp});

        // Full ramp frame plus the first word of the next frame.
        do_reset();
        out_ready = 1'b1;
        for (int r = 0; r < 126; r++) ramp_cols(0, 125);
        ramp_cols(0, 3);
        wait_words(4033, 200);
        idle(3);
        chk("ramp_count",  34'(q.size()), 34'd4033);
        chk("ramp_first",  q[0],    {2'b00, 32'h03020100});
        chk("ramp_w31",    q[31],   {2'b01, 32'h00007D7C});
        chk("ramp_eof",    q[4031], {2'b11, 32'h00007D7C});
        chk("ramp_next",   q[4032], {2'b00, 32'h03020100});
        bad = 0;
        for (int i = 0; i < 4032 && i < q.size(); i++) begin
            if (q[i] !== {(i == 4031), ((i % 32) == 31), ramp_word(i % 32)}) bad++;
        end
        chk("ramp_all_words", 34'(bad), 34'd0);

        // Short stall: three words held, head stable, then drained in order.
        do_reset();
        out_ready = 1'b0;
        ramp_cols(0, 11);
        idle(3);
        chk("hold_valid", 34'(out_valid), 34'd1);
        chk("hold_data",  34'(out_data),  34'(ramp_word(0)));
        idle(2);
        chk("hold_data2", 34'(out_data),  34'(ramp_word(0)));
        out_ready = 1'b1;
        wait_words(3, 20);
        idle(3);
        chk("short_count", 34'(q.size()), 34'd3);
        for (int i = 0; i < 3; i++) chk("short_word", q[i], {2'b00, ramp_word(i)});
        chk("short_ovf", 34'(overflow), 34'd0);

        // Full FIFO with a push and pop on the same edge: nothing dropped.
        do_reset();
        out_ready = 1'b0;
        ramp_cols(0, 18);
        out_ready = 1'b1;
        beat(8'd19, 8'd0);
        out_ready = 1'b0;
        idle(2);
        chk("fullpop_ovf",   34'(overflow), 34'd0);
        chk("fullpop_first", 34'(q.size()), 34'd1);
        out_ready = 1'b1;
        wait_words(5, 20);
        idle(3);
        chk("fullpop_count", 34'(q.size()), 34'd5);
        chk("fullpop_w1",    q[1], {2'b00, ramp_word(1)});
        chk("fullpop_w4",    q[4], {2'b00, ramp_word(4)});

        // Sustained stall: fifth word dropped, framing preserved.
        do_reset();
        out_ready = 1'b0;
        ramp_cols(0, 19);
        idle(2);
        chk("stall_ovf", 34'(overflow), 34'd1);
        out_ready = 1'b1;
        ramp_cols(20, 125);
        ramp_cols(0, 3);
        wait_words(32, 40);
        idle(4);
        chk("stall_count", 34'(q.size()), 34'd32);
        chk("stall_w3",    q[3],  {2'b00, ramp_word(3)});
        chk("stall_w5",    q[4],  {2'b00, ramp_word(5)});
        chk("stall_eol",   q[30], {2'b01, ramp_word(31)});
        chk("stall_row1",  q[31], {2'b00, 32'h03020100});
        chk("stall_ovf_sticky", 34'(overflow), 34'd1);

        // Reset in the middle of a row with words queued.
        out_ready = 1'b0;
        ramp_cols(4, 9);
        chk("pre_rst_valid", 34'(out_valid), 34'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_outputs", {out_valid, out_eol, out_eof, out_data}, 34'd0);
        chk("rst_ovf",     34'(overflow), 34'd0);
        rst = 1'b0;
        q.delete();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) beat(8'(i), 8'd0);
        wait_words(1, 20);
        idle(2);
        chk("post_rst_word", q[0], {2'b00, 32'h04030201});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
